// File: rtl/pipe_mem_wb.sv
// rtl/pipe_mem_wb.sv - MEM stage data memory access with MEM/WB pipeline register
module pipe_mem_wb #(
    parameter int DMEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] alu_out,
    input  logic [31:0] rt_data,
    input  logic [31:0] pc4,
    input  logic [31:0] rs_data_out,
    input  logic [4:0]  rf_waddr,
    input  logic        rf_wena,
    input  logic [2:0]  rf_mux_sel,
    input  logic [3:0]  mem_op,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_dmem_out,
    output logic [31:0] wb_pc4,
    output logic [31:0] wb_rs_data_out,
    output logic [4:0]  wb_rf_waddr,
    output logic        wb_rf_wena,
    output logic [2:0]  wb_rf_mux_sel,
    output logic        wb_misalign
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    logic [31:0] mem [0:(2**DMEM_AW)-1];

    logic [DMEM_AW-1:0] idx;
    logic [31:0]        word;
    logic [15:0]        half;
    logic [7:0]         bsel;
    logic [31:0]        load_data;
    logic [31:0]        wdata;
    logic [3:0]         be;
    logic               misalign;
    logic               is_store;

    assign idx  = alu_out[DMEM_AW+1:2];
    assign word = mem[idx];
    assign half = alu_out[1] ? word[31:16] : word[15:0];

    always_comb begin
        bsel = word[7:0];
        case (alu_out[1:0])
            2'd0: bsel = word[7:0];
            2'd1: bsel = word[15:8];
            2'd2: bsel = word[23:16];
            2'd3: bsel = word[31:24];
            default: bsel = word[7:0];
        endcase
    end

    always_comb begin
        load_data = 32'd0;
        wdata     = rt_data;
        be        = 4'b0000;
        misalign  = 1'b0;
        is_store  = 1'b0;
        case (mem_op)
            OP_LW: begin
                misalign  = (alu_out[1:0] != 2'd0);
                load_data = word;
            end
            OP_LH: begin
                misalign  = alu_out[0];
                load_data = {{16{half[15]}}, half};
            end
            OP_LHU: begin
                misalign  = alu_out[0];
                load_data = {16'd0, half};
            end
            OP_LB:  load_data = {{24{bsel[7]}}, bsel};
            OP_LBU: load_data = {24'd0, bsel};
            OP_SW: begin
                misalign = (alu_out[1:0] != 2'd0);
                is_store = 1'b1;
                be       = 4'b1111;
            end
            OP_SH: begin
                misalign = alu_out[0];
                is_store = 1'b1;
                wdata    = {2{rt_data[15:0]}};
                be       = alu_out[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                is_store = 1'b1;
                wdata    = {4{rt_data[7:0]}};
                be       = 4'b0001 << alu_out[1:0];
            end
            default: ;
        endcase
        // A misaligned access produces no load data at all.
        if (misalign)
            load_data = 32'd0;
    end

    // Memory is deliberately left out of reset; only the commit is gated.
    always_ff @(posedge clk) begin
        if (!rst && !stall && !flush && is_store && !misalign) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k])
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb_alu_out     <= 32'd0;
            wb_dmem_out    <= 32'd0;
            wb_pc4         <= 32'd0;
            wb_rs_data_out <= 32'd0;
            wb_rf_waddr    <= 5'd0;
            wb_rf_wena     <= 1'b0;
            wb_rf_mux_sel  <= 3'd0;
            wb_misalign    <= 1'b0;
        end else if (!stall) begin
            wb_alu_out     <= alu_out;
            wb_dmem_out    <= load_data;
            wb_pc4         <= pc4;
            wb_rs_data_out <= rs_data_out;
            wb_rf_waddr    <= rf_waddr;
            wb_rf_wena     <= rf_wena && !misalign;
            wb_rf_mux_sel  <= rf_mux_sel;
            wb_misalign    <= misalign;
        end
    end

endmodule

// File: tb/tb_pipe_mem_wb.sv
// tb/tb_pipe_mem_wb.sv - directed checks of pipe_mem_wb loads, stores, stall, flush and reset
module tb_pipe_mem_wb;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] alu_out, rt_data, pc4, rs_data_out;
    logic [4:0]  rf_waddr;
    logic        rf_wena;
    logic [2:0]  rf_mux_sel;
    logic [3:0]  mem_op;
    logic [31:0] wb_alu_out, wb_dmem_out, wb_pc4, wb_rs_data_out;
    logic [4:0]  wb_rf_waddr;
    logic        wb_rf_wena;
    logic [2:0]  wb_rf_mux_sel;
    logic        wb_misalign;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [3:0] NONE = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4,
                           LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8;

    pipe_mem_wb #(.DMEM_AW(10)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .alu_out(alu_out), .rt_data(rt_data), .pc4(pc4), .rs_data_out(rs_data_out),
        .rf_waddr(rf_waddr), .rf_wena(rf_wena), .rf_mux_sel(rf_mux_sel), .mem_op(mem_op),
        .wb_alu_out(wb_alu_out), .wb_dmem_out(wb_dmem_out), .wb_pc4(wb_pc4),
        .wb_rs_data_out(wb_rs_data_out), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wena(wb_rf_wena),
        .wb_rf_mux_sel(wb_rf_mux_sel), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Apply one MEM instruction, clock it in, and leave outputs settled 1ns later.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] wa, input logic st, input logic fl, input logic rs);
        mem_op   = op;
        alu_out  = addr;
        rt_data  = data;
        rf_waddr = wa;
        stall    = st;
        flush    = fl;
        rst      = rs;
        @(posedge clk);
        #1;
        stall = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        alu_out = 32'h0; rt_data = 32'h0; pc4 = 32'h0; rs_data_out = 32'h0;
        rf_waddr = 5'd0; rf_wena = 1'b1; rf_mux_sel = 3'd2; mem_op = NONE;
        issue(NONE, 32'h44, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1);
        check("reset_alu", wb_alu_out, 32'h0);
        check("reset_wena", {31'd0, wb_rf_wena}, 32'h0);
        check("reset_mux", {29'd0, wb_rf_mux_sel}, 32'h0);

        pc4 = 32'h104; rs_data_out = 32'hCAFE0001;
        issue(SW, 32'h10, 32'h8899AABB, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sw_dmem_zero", wb_dmem_out, 32'h0);
        check("sw_aligned_flag", {31'd0, wb_misalign}, 32'h0);
        check("pass_pc4", wb_pc4, 32'h104);
        check("pass_rs", wb_rs_data_out, 32'hCAFE0001);

        issue(LW, 32'h10, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lw_10", wb_dmem_out, 32'h8899AABB);
        check("lw_wena", {31'd0, wb_rf_wena}, 32'h1);
        issue(LB, 32'h13, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lb_13", wb_dmem_out, 32'hFFFFFF88);
        issue(LBU, 32'h13, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lbu_13", wb_dmem_out, 32'h00000088);
        issue(LH, 32'h12, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lh_12", wb_dmem_out, 32'hFFFF8899);
        issue(LHU, 32'h10, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lhu_10", wb_dmem_out, 32'h0000AABB);
        issue(LB, 32'h10, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lb_10", wb_dmem_out, 32'hFFFFFFBB);

        issue(SB, 32'h11, 32'h55, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(LW, 32'h10, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("sb_11_then_lw", wb_dmem_out, 32'h889955BB);
        issue(SH, 32'h12, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(LW, 32'h10, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("sh_12_then_lw", wb_dmem_out, 32'h123455BB);
        issue(LW, 32'h1010, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lw_addr_wrap", wb_dmem_out, 32'h123455BB);
        issue(4'd9, 32'h10, 32'hDEADBEEF, 5'd4, 1'b0, 1'b0, 1'b0);
        check("op9_dmem_zero", wb_dmem_out, 32'h0);
        issue(LW, 32'h10, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("op9_no_store", wb_dmem_out, 32'h123455BB);

        issue(SW, 32'h20, 32'h01020304, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(SW, 32'h22, 32'hFFFFFFFF, 5'd7, 1'b0, 1'b0, 1'b0);
        check("sw22_misalign", {31'd0, wb_misalign}, 32'h1);
        check("sw22_wena", {31'd0, wb_rf_wena}, 32'h0);
        check("sw22_alu_pass", wb_alu_out, 32'h22);
        issue(LW, 32'h20, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lw20_after_bad_sw", wb_dmem_out, 32'h01020304);
        check("lw20_misalign_clr", {31'd0, wb_misalign}, 32'h0);
        issue(LH, 32'h21, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("lh21_misalign", {31'd0, wb_misalign}, 32'h1);
        check("lh21_dmem_zero", wb_dmem_out, 32'h0);
        issue(SB, 32'h23, 32'hA5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sb23_aligned", {31'd0, wb_misalign}, 32'h0);
        issue(LW, 32'h20, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("sb23_then_lw", wb_dmem_out, 32'hA5020304);

        issue(SW, 32'h30, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(LW, 32'h30, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0);
        check("lw30", wb_dmem_out, 32'h11111111);
        issue(SW, 32'h34, 32'h22222222, 5'd9, 1'b1, 1'b0, 1'b0);
        check("stall_hold_dmem", wb_dmem_out, 32'h11111111);
        check("stall_hold_waddr", {27'd0, wb_rf_waddr}, 32'd3);
        check("stall_hold_alu", wb_alu_out, 32'h30);
        issue(LW, 32'h34, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        issue(SW, 32'h30, 32'h22222222, 5'd9, 1'b1, 1'b0, 1'b0);
        issue(LW, 32'h30, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("stall_no_store", wb_dmem_out, 32'h11111111);

        issue(SW, 32'h30, 32'h33333333, 5'd9, 1'b0, 1'b1, 1'b0);
        check("flush_alu", wb_alu_out, 32'h0);
        check("flush_pc4", wb_pc4, 32'h0);
        check("flush_wena", {31'd0, wb_rf_wena}, 32'h0);
        issue(LW, 32'h30, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("flush_no_store", wb_dmem_out, 32'h11111111);
        issue(SW, 32'h30, 32'h44444444, 5'd9, 1'b1, 1'b1, 1'b0);
        check("flush_stall_bubble", wb_alu_out, 32'h0);
        check("flush_stall_waddr", {27'd0, wb_rf_waddr}, 32'h0);
        issue(LW, 32'h30, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("flush_stall_no_store", wb_dmem_out, 32'h11111111);

        issue(SW, 32'h30, 32'h55555555, 5'd9, 1'b0, 1'b0, 1'b1);
        check("rst_sw_bubble", wb_alu_out, 32'h0);
        issue(LW, 32'h30, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        check("rst_no_store", wb_dmem_out, 32'h11111111);

        rf_wena = 1'b1; rf_mux_sel = 3'd5;
        issue(NONE, 32'h7, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
        check("rst_stall_alu", wb_alu_out, 32'h0);
        check("rst_stall_waddr", {27'd0, wb_rf_waddr}, 32'h0);
        check("rst_stall_pc4", wb_pc4, 32'h0);
        issue(NONE, 32'h7, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0);
        check("post_rst_waddr", {27'd0, wb_rf_waddr}, 32'd5);
        check("post_rst_mux", {29'd0, wb_rf_mux_sel}, 32'd5);
        check("post_rst_alu", wb_alu_out, 32'h7);
        check("post_rst_wena", {31'd0, wb_rf_wena}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_mem_wb.md
PIPE_MEM_WB -- requirements
Module: pipe_mem_wb

Interface
REQ-001 Parameter DMEM_AW, default 10, data memory word-address width; depth is 2**DMEM_AW 32-bit words.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hold MEM/WB register and suppress the store of the current MEM instruction.
REQ-005 flush  in  1  load a bubble into MEM/WB and suppress the store; priority over stall.
REQ-006 alu_out  in  32  EX result; effective byte address for loads and stores.
REQ-007 rt_data  in  32  store data.
REQ-008 pc4, rs_data_out  in  32 each  passed to WB.
REQ-009 rf_waddr  in  5;  rf_wena  in  1;  rf_mux_sel  in  3  WB controls, passed through.
REQ-010 mem_op  in  4  0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 treated as none.
REQ-011 wb_alu_out, wb_dmem_out, wb_pc4, wb_rs_data_out  out  32 each  registered, to WB stage.
REQ-012 wb_rf_waddr  out  5;  wb_rf_wena  out  1;  wb_rf_mux_sel  out  3  registered, to WB stage.
REQ-013 wb_misalign  out  1  registered; 1 when the instruction now in WB made a misaligned access.

Function
REQ-014 Data memory is internal, little-endian: byte lane k = word bits [8k+7:8k]; word index = alu_out[DMEM_AW+1:2]; upper address bits ignored (wrap).
REQ-015 Memory read is combinational from the word index; result captured into wb_dmem_out at the clock edge (1-cycle MEM->WB latency).
REQ-016 LW: wb_dmem_out = word. LH/LHU: halfword at alu_out[1] (0 -> bits 15:0, 1 -> bits 31:16), sign-/zero-extended. LB/LBU: byte at alu_out[1:0], sign-/zero-extended.
REQ-017 Non-load ops: wb_dmem_out = 0.
REQ-018 SW writes all 4 lanes; SH writes lanes {1,0} or {3,2} per alu_out[1] with rt_data[15:0]; SB writes lane alu_out[1:0] with rt_data[7:0]; other lanes unchanged.
REQ-019 Store commits at the rising edge only when not stall, not flush, not rst, and not misaligned.
REQ-020 Misaligned: LW/SW with alu_out[1:0]!=0; LH/LHU/SH with alu_out[0]!=0; bytes never misaligned.
REQ-021 Misaligned access: store suppressed; MEM/WB captures wb_misalign=1, wb_rf_wena=0, wb_dmem_out=0; other fields pass normally.
REQ-022 Normal edge (no stall/flush): all wb_* fields load from corresponding inputs, wb_misalign=0 unless REQ-021.
REQ-023 stall=1, flush=0: all wb_* outputs hold previous values; memory unchanged.
REQ-024 flush=1 (any stall): MEM/WB loads bubble -- all wb_* outputs 0; memory unchanged.
REQ-025 Load followed by store to same word in next cycle: load value is pre-store data (already captured); store then commits.
REQ-026 Store and load in WB to same address never conflict: one MEM instruction per cycle; read in a cycle reflects all stores committed at prior edges.

Reset
REQ-027 rst=1 at an edge: all wb_* outputs 0 (wb_rf_wena=0, wb_misalign=0); overrides stall and flush; no store commits.
REQ-028 Memory contents are not cleared by reset; reset mid-stall discards held WB contents.

Verification
REQ-029 SW alu_out=0x10 rt_data=0x8899AABB, then LW 0x10 -> wb_dmem_out=0x8899AABB one cycle after LW issue.
REQ-030 After REQ-029: LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
REQ-031 SB 0x11 rt_data=0x55 then LW 0x10 -> 0x889955BB; SH 0x12 rt_data=0x1234 then LW 0x10 -> 0x123455BB.
REQ-032 SW 0x22 rt_data=0xFFFFFFFF -> wb_misalign=1, wb_rf_wena=0; LW 0x20 afterwards returns prior contents; LH 0x21 -> wb_misalign=1, wb_dmem_out=0.
REQ-033 SW 0x30 with stall=1 -> outputs hold, LW 0x30 unchanged; same with flush=1 -> all wb_* 0 next cycle; flush and stall both 1 -> bubble.
REQ-034 rf_wena=1, rf_waddr=5, rf_mux_sel=5, alu_out=0x7 with rst=1 -> all wb_* 0; rst=0 next edge -> wb_rf_waddr=5, wb_rf_mux_sel=5, wb_alu_out=0x7.
